param_priority_encoder: RTL and testbench

PARAM_PRIORITY_ENCODER -- requirements
Module: param_priority_encoder

---
 rtl/param_priority_encoder_pkg.sv | 16 +
 rtl/param_priority_encoder_pick.sv | 35 +++
 rtl/param_priority_encoder.sv | 107 ++++++++++
 tb/tb_param_priority_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_priority_encoder_pkg.sv
// Shared definitions for the pending-request priority encoder: default width,
// state encoding and the index-width helper.
package param_priority_encoder_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/param_priority_encoder_pick.sv
// Combinational selector: first set bit of vec at or above start, wrapping
// modulo N. A zero start gives plain lowest-index priority.
module prio_pick
    import param_priority_encoder_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    logic [W-1:0] pos;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            // start is always < N, so one subtraction is enough to wrap
            pos = (int'(start) + k >= N) ? W'(int'(start) + k - N)
                                         : W'(int'(start) + k);
            if (!found && vec[pos]) begin
                found       = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_priority_encoder.sv
// Latches request events into a pending vector and presents them one at a time
// as index/one-hot codes under fixed or round-robin priority, with valid/ready.
module param_priority_encoder
    import param_priority_encoder_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         rr_en,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [N-1:0] pending,
    output logic         multi
);

    state_t       state;
    state_t       state_next;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] sel_start;
    logic         pick_found;
    logic [W-1:0] pick_idx;
    logic [N-1:0] pick_onehot;
    logic         grant;
    logic [N-1:0] clear;
    logic [N-1:0] pending_next;
    logic         multi_next;

    assign sel_start = rr_en ? ptr : '0;

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .vec    (pending),
        .start  (sel_start),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant      = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                // a held code is never replaced; only acceptance opens a slot
                if (out_ready) begin
                    if (pick_found) begin
                        grant = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        clear        = grant ? pick_onehot : '0;
        // req is ORed last so an event arriving on the line being granted survives
        pending_next = req | (pending & ~clear);
        multi_next   = grant && (|(pending & ~pick_onehot));
        ptr_next     = (pick_idx == W'(N - 1)) ? '0 : pick_idx + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            multi   <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            multi   <= multi_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            ptr        <= '0;
        end else if (grant) begin
            out_valid  <= 1'b1;
            out_idx    <= pick_idx;
            out_onehot <= pick_onehot;
            ptr        <= ptr_next;
        end else if (state == PRESENT && out_ready) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
        end
    end

endmodule

// File: tb/tb_param_priority_encoder.sv
// Directed bench for param_priority_encoder: an N=4 instance driven from a
// vector table and an N=8 instance driven by hand-written sequences.
module tb_param_priority_encoder;

    logic       clk;
    logic       rst_n;

    logic [3:0] req4;
    logic       rr4;
    logic       rdy4;
    logic       v4;
    logic [1:0] idx4;
    logic [3:0] oh4;
    logic [3:0] pend4;
    logic       multi4;

    logic [7:0] req8;
    logic       rr8;
    logic       rdy8;
    logic       v8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic [7:0] pend8;
    logic       multi8;

    int tests;
    int fails;

    param_priority_encoder #(.N(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req4),
        .rr_en      (rr4),
        .out_ready  (rdy4),
        .out_valid  (v4),
        .out_idx    (idx4),
        .out_onehot (oh4),
        .pending    (pend4),
        .multi      (multi4)
    );

    param_priority_encoder #(.N(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req8),
        .rr_en      (rr8),
        .out_ready  (rdy8),
        .out_valid  (v8),
        .out_idx    (idx8),
        .out_onehot (oh8),
        .pending    (pend8),
        .multi      (multi8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       rr;
        logic [1:0] exp_idx;
        logic [3:0] exp_oh;
        logic       exp_multi;
    } vec_t;

    vec_t tab [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drain4(input string name);
        int n;
        n    = 0;
        rdy4 = 1'b1;
        while (v4 && n < 12) begin
            tick();
            n++;
        end
        check({name, " drain valid"}, 64'(v4), 64'd0);
        check({name, " drain onehot"}, 64'(oh4), 64'd0);
        rdy4 = 1'b0;
    endtask

    task automatic drain8(input string name);
        int n;
        n    = 0;
        rdy8 = 1'b1;
        while (v8 && n < 24) begin
            tick();
            n++;
        end
        check({name, " drain valid"}, 64'(v8), 64'd0);
        rdy8 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req4  = '0;
        rr4   = 1'b0;
        rdy4  = 1'b0;
        req8  = '0;
        rr8   = 1'b0;
        rdy8  = 1'b0;

        // Pointer history threads through the table: each entry is drained
        // with its own rr setting before the next one starts.
        tab[0] = '{4'b0001, 1'b0, 2'd0, 4'b0001, 1'b0};
        tab[1] = '{4'b0010, 1'b0, 2'd1, 4'b0010, 1'b0};
        tab[2] = '{4'b0100, 1'b0, 2'd2, 4'b0100, 1'b0};
        tab[3] = '{4'b1000, 1'b0, 2'd3, 4'b1000, 1'b0};
        tab[4] = '{4'b0110, 1'b0, 2'd1, 4'b0010, 1'b1};
        tab[5] = '{4'b1001, 1'b1, 2'd3, 4'b1000, 1'b1};
        tab[6] = '{4'b0101, 1'b1, 2'd2, 4'b0100, 1'b1};
        tab[7] = '{4'b0101, 1'b0, 2'd0, 4'b0001, 1'b1};
        tab[8] = '{4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1};

        tick();
        tick();
        check("reset v4", 64'(v4), 64'd0);
        check("reset idx4", 64'(idx4), 64'd0);
        check("reset pend4", 64'(pend4), 64'd0);
        check("reset v8", 64'(v8), 64'd0);
        check("reset oh8", 64'(oh8), 64'd0);
        check("reset multi8", 64'(multi8), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            rr4  = tab[i].rr;
            req4 = tab[i].req;
            tick();
            req4 = '0;
            tick();
            check($sformatf("tab%0d valid", i), 64'(v4), 64'd1);
            check($sformatf("tab%0d idx", i), 64'(idx4), 64'(tab[i].exp_idx));
            check($sformatf("tab%0d onehot", i), 64'(oh4), 64'(tab[i].exp_oh));
            check($sformatf("tab%0d multi", i), 64'(multi4), 64'(tab[i].exp_multi));
            drain4($sformatf("tab%0d", i));
        end

        // fixed priority burst: 1, 4, 7 back to back
        rr8  = 1'b0;
        rdy8 = 1'b1;
        req8 = 8'b1001_0010;
        tick();
        req8 = '0;
        tick();
        check("burst g0 valid", 64'(v8), 64'd1);
        check("burst g0 idx", 64'(idx8), 64'd1);
        check("burst g0 multi", 64'(multi8), 64'd1);
        tick();
        check("burst g1 valid", 64'(v8), 64'd1);
        check("burst g1 idx", 64'(idx8), 64'd4);
        check("burst g1 multi", 64'(multi8), 64'd1);
        tick();
        check("burst g2 valid", 64'(v8), 64'd1);
        check("burst g2 idx", 64'(idx8), 64'd7);
        check("burst g2 multi", 64'(multi8), 64'd0);
        tick();
        check("burst end valid", 64'(v8), 64'd0);
        check("burst end onehot", 64'(oh8), 64'd0);

        // round-robin with all lines requesting continuously
        rr8  = 1'b1;
        req8 = 8'hFF;
        tick();
        tick();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("rr%0d valid", k), 64'(v8), 64'd1);
            check($sformatf("rr%0d idx", k), 64'(idx8), 64'(k % 8));
            tick();
        end
        req8 = '0;
        drain8("rr");
        do_reset();

        // stall with a re-request on the held line
        rr8  = 1'b0;
        rdy8 = 1'b0;
        req8 = 8'h08;
        tick();
        req8 = '0;
        tick();
        check("stall first valid", 64'(v8), 64'd1);
        check("stall first idx", 64'(idx8), 64'd3);
        for (int c = 0; c < 5; c++) begin
            req8 = (c == 2) ? 8'h08 : 8'h00;
            tick();
            check($sformatf("stall%0d idx", c), 64'(idx8), 64'd3);
            check($sformatf("stall%0d onehot", c), 64'(oh8), 64'h08);
            check($sformatf("stall%0d valid", c), 64'(v8), 64'd1);
        end
        req8 = '0;
        check("stall pend3", 64'(pend8[3]), 64'd1);
        rdy8 = 1'b1;
        tick();
        check("stall again valid", 64'(v8), 64'd1);
        check("stall again idx", 64'(idx8), 64'd3);
        check("stall again pend", 64'(pend8), 64'd0);
        tick();
        check("stall done valid", 64'(v8), 64'd0);
        rdy8 = 1'b0;

        // asynchronous reset while a code is held and lines are pending
        req8 = 8'b0000_1101;
        tick();
        req8 = '0;
        tick();
        check("prerst valid", 64'(v8), 64'd1);
        check("prerst idx", 64'(idx8), 64'd0);
        check("prerst pend", 64'(pend8), 64'h0C);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst valid", 64'(v8), 64'd0);
        check("async rst idx", 64'(idx8), 64'd0);
        check("async rst onehot", 64'(oh8), 64'd0);
        check("async rst pend", 64'(pend8), 64'd0);
        check("async rst multi", 64'(multi8), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("postrst%0d valid", c), 64'(v8), 64'd0);
            check($sformatf("postrst%0d pend", c), 64'(pend8), 64'd0);
        end
        // pointer was 1 before reset; a cleared pointer picks line 0, not 7
        rr8  = 1'b1;
        req8 = 8'h81;
        tick();
        req8 = '0;
        tick();
        check("postrst grant valid", 64'(v8), 64'd1);
        check("postrst grant idx", 64'(idx8), 64'd0);
        check("postrst grant multi", 64'(multi8), 64'd1);
        drain8("postrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
